// File: rtl/instr_fetch_ctrl_pkg.sv
// Shared widths, types and encodings for the instruction fetch sequencer.
package instr_fetch_ctrl_pkg;

    localparam int PC_W    = 8;
    localparam int INSTR_W = 9;

    typedef logic [PC_W-1:0]    pc_t;
    typedef logic [INSTR_W-1:0] instr_t;

    localparam instr_t HALT_INSTR = 9'h1FF;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FETCH  = 2'd1,
        HALTED = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/instr_fetch_ctrl_out_reg.sv
// One-entry valid/ready output register holding a fetched instruction and its address.
import instr_fetch_ctrl_pkg::*;

module fetch_out_reg (
    input  logic   clk,
    input  logic   reset,
    input  logic   load,
    input  logic   flush,
    input  instr_t load_instr,
    input  pc_t    load_pc,
    output instr_t instr_out,
    output pc_t    pc_out,
    output logic   instr_valid
);

    // flush only drops valid; the stale data is harmless once valid is low
    always_ff @(posedge clk) begin
        if (reset) begin
            instr_out   <= '0;
            pc_out      <= '0;
            instr_valid <= 1'b0;
        end else if (flush) begin
            instr_valid <= 1'b0;
        end else if (load) begin
            instr_out   <= load_instr;
            pc_out      <= load_pc;
            instr_valid <= 1'b1;
        end
    end

endmodule

// File: rtl/instr_fetch_ctrl.sv
// Fetch sequencer: owns the PC, drives the combinational imem read, and hands
// instructions to decode through a one-entry valid/ready register.
//
// state  | meaning
// IDLE   | waiting for start, output register empty
// FETCH  | fetching one word per free output slot, branches redirect the PC
// HALTED | HALT word loaded; waits for it to be handed off, then raises done
import instr_fetch_ctrl_pkg::*;

module instr_fetch_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  pc_t              start_addr,
    output pc_t              imem_addr,
    input  instr_t           imem_instr,
    output instr_t           instr_out,
    output pc_t              pc_out,
    output logic             instr_valid,
    input  logic             instr_ready,
    input  logic             branch_taken,
    input  logic             branch_abs,
    input  pc_t              branch_off,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] instr_count
);

    fetch_state_t state;
    pc_t          pc;
    logic         hs;
    logic         load_ok;
    logic         redirect;
    logic         load;
    logic         flush;
    pc_t          branch_target;

    assign imem_addr     = pc;
    assign busy          = (state == FETCH);
    assign hs            = instr_valid & instr_ready;
    assign load_ok       = !instr_valid | hs;
    assign redirect      = (state == FETCH) & !start & hs & branch_taken;
    assign branch_target = branch_abs ? branch_off : pc_t'(pc_out + branch_off);

    // start flushes from any state; in IDLE the register is already empty
    assign flush = start | redirect | ((state == HALTED) & hs);
    assign load  = (state == FETCH) & !start & !redirect & load_ok;

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            pc          <= '0;
            done        <= 1'b0;
            instr_count <= '0;
        end else begin
            if (hs && (instr_count != {CNT_W{1'b1}}))
                instr_count <= instr_count + 1'b1;

            if (start) begin
                pc          <= start_addr;
                instr_count <= '0;
                done        <= 1'b0;
                state       <= FETCH;
            end else begin
                case (state)
                    FETCH: begin
                        if (redirect) begin
                            pc <= branch_target;
                        end else if (load_ok) begin
                            if (imem_instr == HALT_INSTR)
                                state <= HALTED;
                            else
                                pc <= pc + 1'b1;
                        end
                    end
                    HALTED: begin
                        if (hs)
                            done <= 1'b1;
                    end
                    IDLE: ;
                    default: state <= IDLE;
                endcase
            end
        end
    end

    fetch_out_reg u_out_reg (
        .clk         (clk),
        .reset       (reset),
        .load        (load),
        .flush       (flush),
        .load_instr  (imem_instr),
        .load_pc     (pc),
        .instr_out   (instr_out),
        .pc_out      (pc_out),
        .instr_valid (instr_valid)
    );

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Directed bench for instr_fetch_ctrl with a combinational instruction memory model.
module tb_instr_fetch_ctrl;

    logic        clk;
    logic        reset;
    logic        start;
    logic [7:0]  start_addr;
    logic [7:0]  imem_addr;
    logic [8:0]  imem_instr;
    logic [8:0]  instr_out;
    logic [7:0]  pc_out;
    logic        instr_valid;
    logic        instr_ready;
    logic        branch_taken;
    logic        branch_abs;
    logic [7:0]  branch_off;
    logic        busy;
    logic        done;
    logic [15:0] instr_count;

    logic [8:0]  mem [256];

    int errors = 0;
    int checks = 0;

    assign imem_instr = mem[imem_addr];

    instr_fetch_ctrl dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .start_addr   (start_addr),
        .imem_addr    (imem_addr),
        .imem_instr   (imem_instr),
        .instr_out    (instr_out),
        .pc_out       (pc_out),
        .instr_valid  (instr_valid),
        .instr_ready  (instr_ready),
        .branch_taken (branch_taken),
        .branch_abs   (branch_abs),
        .branch_off   (branch_off),
        .busy         (busy),
        .done         (done),
        .instr_count  (instr_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_valid"}, 32'(instr_valid), 32'd0);
        chk({tag, "_addr"},  32'(imem_addr),   32'd0);
        chk({tag, "_busy"},  32'(busy),        32'd0);
        chk({tag, "_done"},  32'(done),        32'd0);
        chk({tag, "_count"}, 32'(instr_count), 32'd0);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 9'h000;
        reset = 1'b1; start = 1'b0; start_addr = 8'h00; instr_ready = 1'b0;
        branch_taken = 1'b0; branch_abs = 1'b0; branch_off = 8'h00;

        // reset then idle
        tick(); tick();
        chk_idle_outputs("reset");
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk_idle_outputs("idle");
        end

        // straight-line run to HALT
        mem[0] = 9'h001; mem[1] = 9'h002; mem[2] = 9'h003; mem[3] = 9'h1FF;
        instr_ready = 1'b1; start = 1'b1; start_addr = 8'h00;
        tick();
        start = 1'b0;
        chk("run_busy",  32'(busy),        32'd1);
        chk("run_valid0", 32'(instr_valid), 32'd0);
        tick();
        chk("run_pc0",   32'(pc_out),      32'h00);
        chk("run_ins0",  32'(instr_out),   32'h001);
        tick();
        chk("run_pc1",   32'(pc_out),      32'h01);
        tick();
        chk("run_pc2",   32'(pc_out),      32'h02);
        tick();
        chk("run_pc3",   32'(pc_out),      32'h03);
        chk("run_halt",  32'(instr_out),   32'h1FF);
        chk("run_busyh", 32'(busy),        32'd0);
        chk("run_done0", 32'(done),        32'd0);
        tick();
        chk("run_done",  32'(done),        32'd1);
        chk("run_count", 32'(instr_count), 32'd4);
        chk("run_validh", 32'(instr_valid), 32'd0);
        chk("run_busyd", 32'(busy),        32'd0);
        tick();
        chk("run_done_hold", 32'(done),    32'd1);

        // restart from HALTED, then stall
        start = 1'b1; start_addr = 8'h00; instr_ready = 1'b0;
        tick();
        start = 1'b0;
        chk("restart_done",  32'(done),        32'd0);
        chk("restart_count", 32'(instr_count), 32'd0);
        chk("restart_busy",  32'(busy),        32'd1);
        instr_ready = 1'b1;
        tick();
        chk("stall_pc0", 32'(pc_out), 32'h00);
        tick();
        instr_ready = 1'b0;
        chk("stall_pc1", 32'(pc_out), 32'h01);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_ins",   32'(instr_out),   32'h002);
            chk("stall_pc",    32'(pc_out),      32'h01);
            chk("stall_addr",  32'(imem_addr),   32'h02);
            chk("stall_count", 32'(instr_count), 32'd1);
        end
        instr_ready = 1'b1;
        tick();
        chk("resume_pc",    32'(pc_out),      32'h02);
        chk("resume_ins",   32'(instr_out),   32'h003);
        chk("resume_count", 32'(instr_count), 32'd2);

        // reset mid-run while an instruction is held
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk_idle_outputs("midreset");
        chk("midreset_pc",  32'(pc_out),    32'h00);
        chk("midreset_ins", 32'(instr_out), 32'h000);

        // relative branch backwards by 3
        mem[5] = 9'h055; mem[6] = 9'h066; mem[2] = 9'h022;
        start = 1'b1; start_addr = 8'h05;
        tick();
        start = 1'b0;
        tick();
        chk("rel_pc5", 32'(pc_out), 32'h05);
        branch_taken = 1'b1; branch_abs = 1'b0; branch_off = 8'hFD;
        tick();
        branch_taken = 1'b0;
        chk("rel_valid", 32'(instr_valid), 32'd0);
        chk("rel_addr",  32'(imem_addr),   32'h02);
        chk("rel_count", 32'(instr_count), 32'd1);
        tick();
        chk("rel_pc",  32'(pc_out),    32'h02);
        chk("rel_ins", 32'(instr_out), 32'h022);

        // PC wrap, then absolute branch with HALT on imem_instr
        mem[8'hFE] = 9'h0AA; mem[8'hFF] = 9'h0BB; mem[0] = 9'h001; mem[1] = 9'h1FF;
        mem[8'h10] = 9'h0CC;
        start = 1'b1; start_addr = 8'hFE;
        tick();
        start = 1'b0;
        tick();
        chk("wrap_pcFE", 32'(pc_out), 32'hFE);
        tick();
        chk("wrap_pcFF", 32'(pc_out), 32'hFF);
        tick();
        chk("wrap_pc00", 32'(pc_out), 32'h00);
        chk("wrap_imem", 32'(imem_instr), 32'h1FF);
        branch_taken = 1'b1; branch_abs = 1'b1; branch_off = 8'h10;
        tick();
        branch_taken = 1'b0;
        chk("abs_busy",  32'(busy),        32'd1);
        chk("abs_valid", 32'(instr_valid), 32'd0);
        chk("abs_addr",  32'(imem_addr),   32'h10);
        tick();
        chk("abs_pc",    32'(pc_out),      32'h10);
        chk("abs_ins",   32'(instr_out),   32'h0CC);
        chk("abs_count", 32'(instr_count), 32'd3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
